// File: rtl/ttt_if.sv
// Handshake bundle between the tic-tac-toe game engine and the UART user block.
// Signal names are seen from the engine: i_* flow into it, o_* flow out of it.
interface ttt_if;
    logic [3:0]  i_move;
    logic        i_validmove_stb;
    logic        i_busy;
    logic [17:0] o_board;
    logic [1:0]  o_result;
    logic        o_result_stb;
    logic        o_needinput;

    // engine side
    modport master (
        input  i_move, i_validmove_stb, i_busy,
        output o_board, o_result, o_result_stb, o_needinput
    );

    // user-interface side
    modport slave (
        output i_move, i_validmove_stb, i_busy,
        input  o_board, o_result, o_result_stb, o_needinput
    );
endinterface

// File: rtl/ttt_engine.sv
// Tic-tac-toe game engine: owns the board, validates user (O) moves, picks the
// FPGA (X) reply with a five-pass sequential scan, and reports win/draw.
module ttt_engine #(
    parameter bit FPGA_FIRST = 1'b0
) (
    input  logic  i_clk,
    input  logic  i_reset,
    ttt_if.master io_bus
);
    localparam logic [1:0] P_O = 2'b01;
    localparam logic [1:0] P_X = 2'b10;

    typedef enum logic [3:0] {
        S_NEWGAME, S_WAITIDLE, S_WAITMOVE, S_CHECK, S_APPLYO, S_EVALO,
        S_SCAN, S_APPLYX, S_EVALX, S_REPORT, S_ACK, S_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [17:0] r_board;
    logic [1:0]  r_result, r_pend;
    logic        r_result_stb, r_needinput;
    logic [3:0]  r_move;       // user square, then reused for the chosen X square
    logic [2:0]  r_pass;       // scan pass 0..4
    logic [3:0]  r_idx;        // candidate index inside the pass

    logic [3:0]  w_cand;
    logic        w_last, w_empty, w_hit;
    logic        w_move_ok, w_xwin, w_owin, w_full;

    // square n lives in bits [19-2n:18-2n]; out-of-range squares read as empty
    function automatic logic [1:0] sq_get(input logic [17:0] b, input logic [3:0] n);
        logic [1:0] v;
        v = 2'b00;
        for (int k = 1; k <= 9; k++)
            if (n == 4'(k)) v = b[18-2*k +: 2];
        return v;
    endfunction

    function automatic logic [17:0] sq_set(input logic [17:0] b, input logic [3:0] n,
                                           input logic [1:0] v);
        logic [17:0] r;
        r = b;
        for (int k = 1; k <= 9; k++)
            if (n == 4'(k)) r[18-2*k +: 2] = v;
        return r;
    endfunction

    function automatic logic has_line(input logic [17:0] b, input logic [1:0] p);
        logic [1:0] s [1:9];
        for (int k = 1; k <= 9; k++) s[k] = b[18-2*k +: 2];
        return (s[1] == p && s[2] == p && s[3] == p) || (s[4] == p && s[5] == p && s[6] == p) ||
               (s[7] == p && s[8] == p && s[9] == p) || (s[1] == p && s[4] == p && s[7] == p) ||
               (s[2] == p && s[5] == p && s[8] == p) || (s[3] == p && s[6] == p && s[9] == p) ||
               (s[1] == p && s[5] == p && s[9] == p) || (s[3] == p && s[5] == p && s[7] == p);
    endfunction

    function automatic logic is_full(input logic [17:0] b);
        logic f;
        f = 1'b1;
        for (int k = 1; k <= 9; k++)
            if (b[18-2*k +: 2] == 2'b00) f = 1'b0;
        return f;
    endfunction

    // board evaluation and the current scan candidate
    always_comb begin
        w_cand = 4'd0;
        w_last = 1'b1;
        case (r_pass)
            3'd2: w_cand = 4'd5;
            3'd3: begin
                case (r_idx[1:0])
                    2'd0:    w_cand = 4'd1;
                    2'd1:    w_cand = 4'd3;
                    2'd2:    w_cand = 4'd7;
                    default: w_cand = 4'd9;
                endcase
                w_last = (r_idx == 4'd3);
            end
            default: begin
                w_cand = r_idx + 4'd1;
                w_last = (r_idx == 4'd8);
            end
        endcase
        w_empty = (sq_get(r_board, w_cand) == 2'b00);
        case (r_pass)
            3'd0:    w_hit = w_empty && has_line(sq_set(r_board, w_cand, P_X), P_X);
            3'd1:    w_hit = w_empty && has_line(sq_set(r_board, w_cand, P_O), P_O);
            default: w_hit = w_empty;
        endcase
        w_move_ok = (r_move >= 4'd1) && (r_move <= 4'd9) && (sq_get(r_board, r_move) == 2'b00);
        w_xwin    = has_line(r_board, P_X);
        w_owin    = has_line(r_board, P_O);
        w_full    = is_full(r_board);
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_NEWGAME:  w_state_nxt = FPGA_FIRST ? S_SCAN : S_WAITIDLE;
            S_WAITIDLE: if (!io_bus.i_busy) w_state_nxt = S_WAITMOVE;
            S_WAITMOVE: if (io_bus.i_validmove_stb) w_state_nxt = S_CHECK;
            S_CHECK:    w_state_nxt = w_move_ok ? S_APPLYO : S_WAITIDLE;
            S_APPLYO:   w_state_nxt = S_EVALO;
            S_EVALO:    w_state_nxt = (w_owin || w_full) ? S_REPORT : S_SCAN;
            S_SCAN:     if (w_hit) w_state_nxt = S_APPLYX;
            S_APPLYX:   w_state_nxt = S_EVALX;
            S_EVALX:    w_state_nxt = (w_xwin || w_full) ? S_REPORT : S_WAITIDLE;
            S_REPORT:   if (!io_bus.i_busy) w_state_nxt = S_ACK;
            S_ACK:      if (io_bus.i_busy) w_state_nxt = S_DONE;
            S_DONE:     if (!io_bus.i_busy) w_state_nxt = S_NEWGAME;
            default:    w_state_nxt = S_NEWGAME;
        endcase
    end

    // state register plus board, scan counters and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_NEWGAME;
            r_board      <= '0;
            r_result     <= 2'd0;
            r_pend       <= 2'd0;
            r_result_stb <= 1'b0;
            r_needinput  <= 1'b0;
            r_move       <= 4'd0;
            r_pass       <= 3'd0;
            r_idx        <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_NEWGAME: begin
                    r_board <= '0;
                    r_pass  <= 3'd0;
                    r_idx   <= 4'd0;
                end
                S_WAITIDLE: if (!io_bus.i_busy) r_needinput <= 1'b1;
                S_WAITMOVE: if (io_bus.i_validmove_stb) begin
                    r_move      <= io_bus.i_move;
                    r_needinput <= 1'b0;
                end
                S_APPLYO: r_board <= sq_set(r_board, r_move, P_O);
                S_EVALO: begin
                    r_pass <= 3'd0;
                    r_idx  <= 4'd0;
                    if (w_owin)      r_pend <= 2'd2;
                    else if (w_full) r_pend <= 2'd3;
                end
                S_SCAN: begin
                    if (w_hit) begin
                        r_move <= w_cand;
                    end else if (w_last) begin
                        // pass 4 always hits on a non-full board; wrap is only a safety net
                        r_pass <= (r_pass == 3'd4) ? 3'd0 : r_pass + 3'd1;
                        r_idx  <= 4'd0;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_APPLYX: r_board <= sq_set(r_board, r_move, P_X);
                S_EVALX: begin
                    if (w_xwin)      r_pend <= 2'd1;
                    else if (w_full) r_pend <= 2'd3;
                end
                S_REPORT: if (!io_bus.i_busy) begin
                    r_result     <= r_pend;
                    r_result_stb <= 1'b1;
                end
                S_ACK:  if (io_bus.i_busy) r_result_stb <= 1'b0;
                S_DONE: if (!io_bus.i_busy) r_result <= 2'd0;
                default: ;
            endcase
        end
    end

    assign io_bus.o_board      = r_board;
    assign io_bus.o_result     = r_result;
    assign io_bus.o_result_stb = r_result_stb;
    assign io_bus.o_needinput  = r_needinput;
endmodule

// File: tb/tb_ttt_engine.sv
// Scoreboard bench for ttt_engine: a user-block driver plays directed and random
// games against a rule-level game model; a monitor checks every input request
// and result the engine presents against the expected-event queue.
module tb_ttt_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    ttt_if bus0();
    ttt_if bus1();

    ttt_engine #(.FPGA_FIRST(1'b0)) dut0 (.i_clk(clk), .i_reset(rst0), .io_bus(bus0));
    ttt_engine #(.FPGA_FIRST(1'b1)) dut1 (.i_clk(clk), .i_reset(rst1), .io_bus(bus1));

    typedef struct {
        bit          is_res;
        logic [17:0] board;
        logic [1:0]  result;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   mb [1:9];   // model board: 0 empty, 1 O, 2 X
    int   ln [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                        '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // ---------------- reference game model ----------------
    function automatic bit m_line(input int p);
        for (int l = 0; l < 8; l++)
            if (mb[ln[l][0]] == p && mb[ln[l][1]] == p && mb[ln[l][2]] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_full();
        for (int s = 1; s <= 9; s++) if (mb[s] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [17:0] m_pack();
        logic [17:0] b;
        b = '0;
        for (int s = 1; s <= 9; s++) b[18-2*s +: 2] = 2'(mb[s]);
        return b;
    endfunction

    function automatic bit m_completes(input int s, input int p);
        bit w;
        mb[s] = p;
        w = m_line(p);
        mb[s] = 0;
        return w;
    endfunction

    // X strategy: win, block, centre, corner, first free
    function automatic int m_pick();
        int corners [4] = '{1, 3, 7, 9};
        for (int s = 1; s <= 9; s++) if (mb[s] == 0 && m_completes(s, 2)) return s;
        for (int s = 1; s <= 9; s++) if (mb[s] == 0 && m_completes(s, 1)) return s;
        if (mb[5] == 0) return 5;
        for (int c = 0; c < 4; c++) if (mb[corners[c]] == 0) return corners[c];
        for (int s = 1; s <= 9; s++) if (mb[s] == 0) return s;
        return 0;
    endfunction

    task automatic m_reset();
        for (int s = 1; s <= 9; s++) mb[s] = 0;
    endtask

    task automatic push(input bit r, input logic [17:0] b, input logic [1:0] res);
        exp_t e;
        e.is_res = r;
        e.board  = b;
        e.result = res;
        q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic        pn = 1'b0, pr = 1'b0;
    logic [17:0] need_board = '0;

    task automatic pop_cmp(input bit is_res, output logic [17:0] eb);
        exp_t e;
        eb = '0;
        if (q.size() == 0) begin
            fail_now("scoreboard_empty");
            return;
        end
        e  = q.pop_front();
        eb = e.board;
        chk(is_res ? "event_kind_result" : "event_kind_need", 32'(is_res), 32'(e.is_res));
        chk("event_board", 32'(bus0.o_board), 32'(e.board));
        if (is_res && e.is_res) chk("event_result", 32'(bus0.o_result), 32'(e.result));
    endtask

    always @(negedge clk) begin
        logic [17:0] eb;
        if (mon_en) begin
            if (bus0.o_needinput && bus0.o_result_stb) chk("need_and_result_exclusive", 1, 0);
            if (bus0.o_needinput && pn) chk("board_stable_need", 32'(bus0.o_board), 32'(need_board));
            if (bus0.o_needinput && !pn) begin
                pop_cmp(1'b0, eb);
                need_board <= eb;
            end
            if (bus0.o_result_stb && !pr) pop_cmp(1'b1, eb);
        end
        pn <= bus0.o_needinput;
        pr <= bus0.o_result_stb;
    end

    // ---------------- driver ----------------
    task automatic wait_need(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus0.o_needinput;
        end
    endtask

    task automatic play(input int m, input bit bogus, input int busy_cyc, output bit ended);
        bit ok;
        int x;
        ended = 1'b0;
        wait_need(ok);
        if (!ok) begin
            fail_now("need_timeout");
            return;
        end
        if (m >= 1 && m <= 9 && mb[m] == 0) begin
            mb[m] = 1;
            if (m_line(1))    begin push(1'b1, m_pack(), 2'd2); ended = 1'b1; end
            else if (m_full()) begin push(1'b1, m_pack(), 2'd3); ended = 1'b1; end
            else begin
                x = m_pick();
                mb[x] = 2;
                if (m_line(2))     begin push(1'b1, m_pack(), 2'd1); ended = 1'b1; end
                else if (m_full()) begin push(1'b1, m_pack(), 2'd3); ended = 1'b1; end
                else push(1'b0, m_pack(), 2'd0);
            end
        end else begin
            push(1'b0, m_pack(), 2'd0);
        end
        bus0.i_move = 4'(m);
        bus0.i_validmove_stb = 1'b1;
        @(negedge clk);
        chk("need_drop_after_strobe", 32'(bus0.o_needinput), 0);
        if (bogus) begin
            // extra strobe while the engine is checking: must be ignored
            bus0.i_move = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        bus0.i_validmove_stb = 1'b0;
        if (busy_cyc > 0) begin
            bus0.i_busy = 1'b1;
            repeat (busy_cyc) @(negedge clk);
            bus0.i_busy = 1'b0;
        end
    endtask

    task automatic finish_game(input bit hold, input int cres, input int cboard);
        bit ok, seen;
        if (hold) begin
            bus0.i_busy = 1'b1;
            seen = 1'b0;
            repeat (50) begin
                @(negedge clk);
                if (bus0.o_result_stb) seen = 1'b1;
            end
            chk("result_stb_low_while_busy", 32'(seen), 0);
            bus0.i_busy = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus0.o_result_stb;
        end
        if (!ok) begin
            fail_now("result_timeout");
            return;
        end
        if (cres >= 0) begin
            chk("directed_result", 32'(bus0.o_result), 32'(cres));
            chk("directed_final_board", 32'(bus0.o_board), 32'(cboard));
        end
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("result_stb_hold", 32'(bus0.o_result_stb), 1);
        end
        m_reset();
        push(1'b0, m_pack(), 2'd0);
        bus0.i_busy = 1'b1;
        @(negedge clk);
        chk("result_stb_fall", 32'(bus0.o_result_stb), 0);
        if (hold) begin
            bus0.i_busy = 1'b0;
            repeat (3) @(negedge clk);
            chk("newgame_need", 32'(bus0.o_needinput), 1);
            chk("newgame_board", 32'(bus0.o_board), 0);
        end else begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus0.i_busy = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ended, ok, seen;
        int m, r;
        int e[$];
        int dr [5] = '{5, 2, 4, 3, 9};

        bus0.i_move = 4'd0; bus0.i_validmove_stb = 1'b0; bus0.i_busy = 1'b0;
        bus1.i_move = 4'd0; bus1.i_validmove_stb = 1'b0; bus1.i_busy = 1'b0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        m_reset();
        repeat (3) @(negedge clk);
        chk("reset_board", 32'(bus0.o_board), 0);
        chk("reset_result", 32'(bus0.o_result), 0);
        chk("reset_result_stb", 32'(bus0.o_result_stb), 0);
        chk("reset_needinput", 32'(bus0.o_needinput), 0);

        push(1'b0, m_pack(), 2'd0);
        mon_en = 1'b1;
        rst0 = 1'b0;
        rst1 = 1'b0;

        // FPGA moves first: centre before the first request
        ok = 1'b0; seen = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus1.o_needinput;
            if (bus1.o_result_stb) seen = 1'b1;
        end
        if (!ok) fail_now("fpga_first_need");
        chk("fpga_first_board", 32'(bus1.o_board), 32'h00200);
        chk("fpga_first_no_result", 32'(seen), 0);

        // invalid values, then a valid move, then an occupied square
        play(0, 1'b0, 0, ended);
        play(12, 1'b0, 0, ended);
        play(5, 1'b0, 0, ended);
        wait_need(ok);
        chk("opening_reply_board", 32'(bus0.o_board), 32'h20100);
        chk("opening_no_result", 32'(bus0.o_result_stb), 0);
        play(5, 1'b0, 0, ended);
        wait_need(ok);
        chk("occupied_board_unchanged", 32'(bus0.o_board), 32'h20100);

        // FPGA win, with busy held over the report
        play(9, 1'b0, 0, ended);
        wait_need(ok);
        chk("second_reply_board", 32'(bus0.o_board), 32'h22101);
        play(6, 1'b0, 0, ended);
        chk("fpga_win_ended", 32'(ended), 1);
        finish_game(1'b1, 1, 32'h2A141);

        // draw with blocks
        for (int i = 0; i < 5; i++) play(dr[i], 1'b0, 0, ended);
        chk("draw_ended", 32'(ended), 1);
        finish_game(1'b0, 3, 32'h255A9);

        // reset while the engine is scanning
        wait_need(ok);
        bus0.i_move = 4'd5;
        bus0.i_validmove_stb = 1'b1;
        @(negedge clk);
        bus0.i_validmove_stb = 1'b0;
        repeat (5) @(negedge clk);
        rst0 = 1'b1;
        mon_en = 1'b0;
        @(negedge clk);
        chk("midscan_reset_board", 32'(bus0.o_board), 0);
        chk("midscan_reset_result", 32'(bus0.o_result), 0);
        chk("midscan_reset_stb", 32'(bus0.o_result_stb), 0);
        chk("midscan_reset_need", 32'(bus0.o_needinput), 0);
        q.delete();
        m_reset();
        push(1'b0, m_pack(), 2'd0);
        rst0 = 1'b0;
        mon_en = 1'b1;

        // random games
        for (int g = 0; g < 20; g++) begin
            ended = 1'b0;
            for (int t = 0; t < 40 && !ended; t++) begin
                e.delete();
                for (int s = 1; s <= 9; s++) if (mb[s] == 0) e.push_back(s);
                r = $urandom_range(0, 9);
                if (r < 2) begin
                    r = $urandom_range(0, 7);
                    if (r == 0)      m = 0;
                    else if (r < 7)  m = 9 + r;
                    else begin
                        m = 0;
                        for (int s = 1; s <= 9; s++) if (mb[s] != 0) m = s;
                    end
                end else begin
                    m = e[$urandom_range(0, e.size() - 1)];
                end
                play(m, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), ended);
            end
            if (ended) finish_game(1'b0, -1, 0);
        end

        wait_need(ok);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
